sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Two-client arbiter sharing one sdram_basemod instance between requester A (e.g. capture/write engine) and requester B (e.g. readback/UART engine).
- Each client presents the same call/done handshake as the base module: {write, read} call bits, plus address and write data.
- The arbiter grants round-robin, gates each operation on the base module's ready tags, forwards one transaction at a time and returns read data to the granted client.
- Clocked entirely in the CLOCK1 (133 MHz, phase-shifted SDRAM controller) domain.

Parameters:
- ADDR_W, 24, client/base address width (bank 2 + row 13 + col 9).
- DATA_W, 16, SDRAM data width.
- TIMEOUT, 1023, base-call watchdog limit in cycles (used only with the optional feature).

Ports:
- CLOCK1  in  1  system clock, 133 MHz.
- RESET  in  1  asynchronous, active-low reset.
- A_iCall  in  2  client A call {wr, rd}; held high until the matching A_oDone bit pulses.
- A_iAddr  in  ADDR_W  client A address.
- A_iData  in  DATA_W  client A write data.
- A_oDone  out  2  client A one-cycle done pulse {wr, rd}.
- A_oData  out  DATA_W  client A read data.
- A_oErr  out  1  client A error, valid with the done pulse.
- B_iCall, B_iAddr, B_iData, B_oDone, B_oData, B_oErr: same as the A ports, for client B.
- S_oCall  out  2  to base iCall {wr, rd}.
- S_oAddr  out  ADDR_W  to base address.
- S_oData  out  DATA_W  to base iData.
- S_iDone  in  2  from base oDone.
- S_iData  in  DATA_W  from base oData.
- S_iTag  in  2  from base oTag {wr_busy, rd_busy}; 1 = op not accepted now.

Behaviour:
- Reset (async, RESET low): state=IDLE; all oDone, oErr, S_oCall = 0; S_oAddr, S_oData, A_oData, B_oData = 0; round-robin pointer = A preferred.
- An asserted reset mid-transaction drops S_oCall immediately. No done is ever issued for the aborted call.
- Eligibility: a client is eligible if it has a call bit set whose tag is clear (wr needs S_iTag[1]=0, rd needs S_iTag[0]=0).
  - Within one client, wr takes precedence over rd when both are set and eligible.
  - A client whose wr is tag-blocked but whose rd is clear is eligible for rd.
- IDLE:
  - If exactly one client is eligible, grant it.
  - If both are eligible, grant the one not granted last (pointer toggles after each completed grant).
  - On grant: latch addr, data, op and client ID; go to CALL.
  - No eligible client: stay in IDLE.
- CALL:
  - S_oCall op bit = 1; S_oAddr/S_oData driven from latched values and stable for the whole call.
  - Wait for S_iDone of the same op bit.
  - On the cycle S_iDone is seen: clear S_oCall at that edge; capture S_iData into the client's oData if the op is rd; go to DONE.
  - The other S_iDone bit is ignored.
- DONE (exactly 1 cycle):
  - The granted client's oDone op bit = 1, oErr per the optional feature.
  - Update the pointer; next state IDLE.
  - The client drops its call at the edge ending DONE, so IDLE never re-grants the completed op.
- Latency: grant to S_oCall = 1 cycle (IDLE→CALL edge). Base done to client done = 1 cycle. Minimum re-arbitration gap = 1 IDLE cycle.
- A_oData/B_oData hold their last read value until the next rd completes for that client. Write completion does not change them.
- A client's call bits are sampled only in IDLE. Changes during another client's CALL are not seen until the next IDLE.
- A client dropping its call during its own CALL is a protocol violation; the arbiter still completes the base transaction and pulses done.
- Address/data changes from a client after its grant are ignored (latched copy used).

Optional Feature:
- Macro SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - An 11-bit counter clears on entry to CALL and increments each CALL cycle.
  - If it reaches TIMEOUT with no matching S_iDone: drop S_oCall, go to DONE, pulse the client's done with oErr=1 and leave oData unchanged.
  - The pointer still advances.
- Not defined: no counter; CALL waits indefinitely; A_oErr and B_oErr tied 0.

Test Plan:
- Single write: A_iCall=10, A_iAddr=0x000100, A_iData=0xA000; base done after 7 cycles → S_oCall=10 with addr 0x000100 and data 0xA000 for 7 cycles; A_oDone=10 for one cycle, 1 cycle after base done.
- Contention: A and B both rd in the same cycle after reset → A served first, then B. Both raised again → B then A (round-robin alternation verified over 8 grants).
- Tag gating: S_iTag=10, A wr pending, B rd pending → B rd granted first; A wr granted only after S_iTag[1] returns 0.
- Readback: A wr 0xA1FF to 0x0001FF, then A rd 0x0001FF with base returning 0xA1FF → A_oData=0xA1FF with A_oDone=01. B_oData unchanged at 0.
- Reset mid-call: RESET low 2 cycles during CALL → S_oCall=00 immediately, no client done; after release, the pending call is re-arbitrated from IDLE with the A-preferred pointer.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT=16, base never responds → S_oCall drops after 16 CALL cycles; B_oDone pulses with B_oErr=1; the next request proceeds normally.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Call/done handshake bundle shared by the arbiter clients and the base module.
// master drives a call toward a base; slave answers a client's call.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16
);
    logic [1:0]        call;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        done;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [1:0]        tag;

    modport master (
        output call, addr, wdata,
        input  done, rdata, tag
    );

    modport slave (
        input  call, addr, wdata,
        output done, rdata, err
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin two-client arbiter in front of one sdram_basemod (CLOCK1 domain).
// Optional base-call watchdog enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic            CLOCK1,
    input  logic            RESET,
    sdram_arbiter_if.slave  A,
    sdram_arbiter_if.slave  B,
    sdram_arbiter_if.master S
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALL,
        ST_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ard_q, ard_d;
    logic [DATA_W-1:0] brd_q, brd_d;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [10:0] CNT_LIM = 11'(TIMEOUT - 1);
    logic [10:0]       cnt_q, cnt_d;
    logic              err_q, err_d;
`endif

    logic a_wr, a_rd, a_el;
    logic b_wr, b_rd, b_el;
    logic pick_b, match;
    logic [1:0] op2;

    // wr beats rd inside a client; a tag-blocked wr falls back to rd
    assign a_wr   = A.call[1] & ~S.tag[1];
    assign a_rd   = A.call[0] & ~S.tag[0];
    assign b_wr   = B.call[1] & ~S.tag[1];
    assign b_rd   = B.call[0] & ~S.tag[0];
    assign a_el   = a_wr | a_rd;
    assign b_el   = b_wr | b_rd;
    assign pick_b = b_el & (~a_el | ptr_q);
    assign match  = wr_q ? S.done[1] : S.done[0];
    assign op2    = wr_q ? 2'b10 : 2'b01;

    always_ff @(posedge CLOCK1 or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ard_q   <= '0;
            brd_q   <= '0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ard_q   <= ard_d;
            brd_q   <= brd_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ard_d   = ard_q;
        brd_d   = brd_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (a_el | b_el) begin
                    state_d = ST_CALL;
                    id_d    = pick_b;
                    wr_d    = pick_b ? b_wr : a_wr;
                    addr_d  = pick_b ? B.addr : A.addr;
                    wdata_d = pick_b ? B.wdata : A.wdata;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_CALL: begin
                if (match) begin
                    state_d = ST_DONE;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    if (!wr_q) begin
                        if (id_q) brd_d = S.rdata;
                        else      ard_d = S.rdata;
                    end
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LIM) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = ~id_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        S.call  = 2'b00;
        S.addr  = addr_q;
        S.wdata = wdata_q;
        A.done  = 2'b00;
        B.done  = 2'b00;
        A.rdata = ard_q;
        B.rdata = brd_q;
        A.err   = 1'b0;
        B.err   = 1'b0;
        unique case (state_q)
            ST_CALL: S.call = op2;
            ST_DONE: begin
                if (id_q) B.done = op2;
                else      A.done = op2;
`ifdef SDRAM_ARB_TIMEOUT_EN
                if (id_q) B.err = err_q;
                else      A.err = err_q;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: grant table plus corner-case sequences.
// Timeout sequence is built only when SDRAM_ARB_TIMEOUT_EN is defined.
module tb_sdram_arbiter;

    logic CLOCK1;
    logic RESET;

    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) a_if ();
    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) b_if ();
    sdram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) s_if ();

    sdram_arbiter #(
        .ADDR_W (24),
        .DATA_W (16),
        .TIMEOUT(16)
    ) dut (
        .CLOCK1(CLOCK1),
        .RESET (RESET),
        .A     (a_if),
        .B     (b_if),
        .S     (s_if)
    );

    initial CLOCK1 = 1'b0;
    always #5 CLOCK1 = ~CLOCK1;

    int errors = 0;
    int checks = 0;
    logic [15:0] a_last = 16'h0;
    logic [15:0] b_last = 16'h0;

    typedef struct {
        logic [1:0] ac;
        logic [1:0] bc;
        logic [1:0] tg;
        logic [1:0] ec;
        logic       eb;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic nclk();
        @(negedge CLOCK1);
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic xact(input logic [1:0] ac, input logic [1:0] bc,
                        input logic [1:0] tg, input logic [1:0] ec,
                        input logic eb, input int lat,
                        input logic [15:0] rdv);
        a_if.call  = ac;
        b_if.call  = bc;
        s_if.tag   = tg;
        s_if.rdata = rdv;
        nclk();
        chk("grant_call", s_if.call, ec);
        if (ec == 2'b00) begin
            a_if.call = 2'b00;
            b_if.call = 2'b00;
            s_if.tag  = 2'b00;
            return;
        end
        chk("grant_addr", s_if.addr, eb ? b_if.addr : a_if.addr);
        chk("grant_data", s_if.wdata, eb ? b_if.wdata : a_if.wdata);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) begin
                nclk();
                chk("call_hold", s_if.call, ec);
                chk("addr_hold", s_if.addr, eb ? b_if.addr : a_if.addr);
            end
            chk("no_early_done", {a_if.done, b_if.done}, 4'h0);
            if (k == lat) s_if.done = ec;
        end
        nclk();
        s_if.done = 2'b00;
        chk("call_drop", s_if.call, 2'b00);
        chk("a_done", a_if.done, eb ? 2'b00 : ec);
        chk("b_done", b_if.done, eb ? ec : 2'b00);
        chk("errs", {a_if.err, b_if.err}, 2'b00);
        if (ec == 2'b01) begin
            if (eb) b_last = rdv;
            else    a_last = rdv;
        end
        chk("a_rdata", a_if.rdata, a_last);
        chk("b_rdata", b_if.rdata, b_last);
        a_if.call = 2'b00;
        b_if.call = 2'b00;
        s_if.tag  = 2'b00;
        nclk();
        chk("done_1cyc", {a_if.done, b_if.done}, 4'h0);
    endtask

    initial begin
        // pointer starts at A; each grant hands preference to the other side
        vt[0]  = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0};
        vt[1]  = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b0};
        vt[2]  = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b1};
        vt[3]  = '{2'b01, 2'b01, 2'b00, 2'b01, 1'b0};
        vt[4]  = '{2'b11, 2'b00, 2'b00, 2'b10, 1'b0};
        vt[5]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b0};
        vt[6]  = '{2'b10, 2'b01, 2'b10, 2'b01, 1'b1};
        vt[7]  = '{2'b10, 2'b10, 2'b10, 2'b00, 1'b0};
        vt[8]  = '{2'b10, 2'b10, 2'b00, 2'b10, 1'b0};
        vt[9]  = '{2'b01, 2'b10, 2'b01, 2'b10, 1'b1};
        vt[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
        vt[11] = '{2'b10, 2'b10, 2'b11, 2'b00, 1'b0};
        vt[12] = '{2'b01, 2'b11, 2'b00, 2'b01, 1'b0};
        vt[13] = '{2'b01, 2'b11, 2'b00, 2'b10, 1'b1};

        RESET      = 1'b0;
        a_if.call  = 2'b00;
        a_if.addr  = 24'h0000AA;
        a_if.wdata = 16'hAAAA;
        a_if.tag   = 2'b00;
        b_if.call  = 2'b00;
        b_if.addr  = 24'h0000BB;
        b_if.wdata = 16'hBBBB;
        b_if.tag   = 2'b00;
        s_if.done  = 2'b00;
        s_if.rdata = 16'h0;
        s_if.tag   = 2'b00;
        s_if.err   = 1'b0;

        nclk();
        nclk();
        chk("rst_call", s_if.call, 2'b00);
        chk("rst_addr", s_if.addr, 24'h0);
        chk("rst_wdata", s_if.wdata, 16'h0);
        chk("rst_done", {a_if.done, b_if.done}, 4'h0);
        chk("rst_rdata", {a_if.rdata, b_if.rdata}, 32'h0);
        chk("rst_err", {a_if.err, b_if.err}, 2'b00);
        RESET = 1'b1;
        nclk();

        for (int i = 0; i < 14; i++)
            xact(vt[i].ac, vt[i].bc, vt[i].tg, vt[i].ec, vt[i].eb, 1 + (i % 3),
                 16'hC000 + 16'(i));

        a_if.addr  = 24'h000100;
        a_if.wdata = 16'hA000;
        xact(2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 7, 16'h0);

        // A wr tag-blocked, B rd goes first; A waits for the tag to clear
        a_if.call = 2'b10;
        b_if.call = 2'b01;
        s_if.tag  = 2'b10;
        s_if.rdata = 16'hB0B0;
        nclk();
        chk("tag_b_first", s_if.call, 2'b01);
        chk("tag_b_addr", s_if.addr, b_if.addr);
        s_if.done = 2'b01;
        nclk();
        s_if.done = 2'b00;
        chk("tag_b_done", b_if.done, 2'b01);
        b_last = 16'hB0B0;
        chk("tag_b_rdata", b_if.rdata, b_last);
        b_if.call = 2'b00;
        nclk();
        chk("tag_a_blk0", s_if.call, 2'b00);
        nclk();
        chk("tag_a_blk1", s_if.call, 2'b00);
        s_if.tag = 2'b00;
        nclk();
        chk("tag_a_go", s_if.call, 2'b10);
        chk("tag_a_addr", s_if.addr, a_if.addr);
        s_if.done = 2'b10;
        nclk();
        s_if.done = 2'b00;
        chk("tag_a_done", a_if.done, 2'b10);
        a_if.call = 2'b00;
        nclk();

        // pointer now prefers B
        for (int i = 0; i < 8; i++)
            xact(2'b01, 2'b01, 2'b00, 2'b01, 1'((i % 2) == 0), 2,
                 16'h7000 + 16'(i));

        // reset during B's call; A-preferred pointer afterwards
        a_if.call = 2'b10;
        b_if.call = 2'b10;
        nclk();
        chk("rmc_grant_b", s_if.call, 2'b10);
        chk("rmc_addr_b", s_if.addr, b_if.addr);
        nclk();
        RESET = 1'b0;
        #1;
        chk("rmc_call_drop", s_if.call, 2'b00);
        nclk();
        chk("rmc_no_done0", {a_if.done, b_if.done}, 4'h0);
        chk("rmc_call_low", s_if.call, 2'b00);
        nclk();
        chk("rmc_no_done1", {a_if.done, b_if.done}, 4'h0);
        RESET  = 1'b1;
        a_last = 16'h0;
        b_last = 16'h0;
        chk("rmc_rdata", {a_if.rdata, b_if.rdata}, 32'h0);
        nclk();
        chk("rmc_regrant_a", s_if.call, 2'b10);
        chk("rmc_addr_a", s_if.addr, a_if.addr);
        s_if.done = 2'b10;
        nclk();
        s_if.done = 2'b00;
        chk("rmc_a_done", a_if.done, 2'b10);
        chk("rmc_b_quiet", b_if.done, 2'b00);
        a_if.call = 2'b00;
        nclk();
        chk("rmc_gap", s_if.call, 2'b00);
        nclk();
        chk("rmc_grant_b2", s_if.call, 2'b10);
        chk("rmc_addr_b2", s_if.addr, b_if.addr);
        s_if.done = 2'b10;
        nclk();
        s_if.done = 2'b00;
        chk("rmc_b_done", b_if.done, 2'b10);
        b_if.call = 2'b00;
        nclk();

        a_if.addr  = 24'h0001FF;
        a_if.wdata = 16'hA1FF;
        xact(2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 3, 16'h0);
        a_if.wdata = 16'h1234;
        xact(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 2, 16'hA1FF);
        chk("rb_a_data", a_if.rdata, 16'hA1FF);
        chk("rb_b_data", b_if.rdata, 16'h0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        b_if.call  = 2'b01;
        s_if.rdata = 16'hDEAD;
        nclk();
        chk("to_call1", s_if.call, 2'b01);
        for (int k = 2; k <= 16; k++) begin
            nclk();
            chk("to_call_hold", s_if.call, 2'b01);
            chk("to_no_done", b_if.done, 2'b00);
        end
        nclk();
        chk("to_call_drop", s_if.call, 2'b00);
        chk("to_b_done", b_if.done, 2'b01);
        chk("to_b_err", b_if.err, 1'b1);
        chk("to_b_rdata", b_if.rdata, b_last);
        b_if.call = 2'b00;
        nclk();
        chk("to_err_clr", b_if.err, 1'b0);
        xact(2'b00, 2'b01, 2'b00, 2'b01, 1'b1, 2, 16'h5A5A);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
